// File: rtl/sched_pkg.sv
// Shared types for the burst round-robin scheduler (states, mode encoding, arbitration helper).
// Used by burst_rr_scheduler, whose optional completion wait is SCHED_WAIT_CMPLT_EN.
package sched_pkg;

   typedef enum logic [1:0] {IDLE, GRANT, DRAIN} sched_state_t;

   typedef logic [1:0] mode_t;

   localparam mode_t MODE_NONE = 2'b00;

   // With both slaves requesting the rr pointer decides, otherwise the lone requester wins.
   function automatic logic pick_slave(input logic req0, input logic req1, input logic rr_ptr);
      return (req0 && req1) ? rr_ptr : !req0;
   endfunction

endpackage

// File: rtl/burst_counter.sv
// Beat counter for one burst: synchronous clear, increment, and a flag marking the final beat slot.
module burst_counter #(
   parameter int BURST_LEN = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic last
);

   localparam int CW = $clog2(BURST_LEN + 1);

   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc) begin
         count_d = count_q + CW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == CW'(BURST_LEN - 1));

endmodule

// File: rtl/burst_rr_scheduler.sv
// Two-slave burst-granular round-robin scheduler feeding the datapath input FIFO.
// Define SCHED_WAIT_CMPLT_EN to hold DRAIN until the downstream master pulses mstr_cmplt.
module burst_rr_scheduler
   import sched_pkg::*;
#(
   parameter int DW        = 32,
   parameter int BURST_LEN = 16
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [1:0]    slv0_mode,
   input  logic [DW-1:0] slv0_data,
   input  logic          slv0_data_valid,
   input  logic [7:0]    slv0_proc_val,
   output logic          slv0_ready,
   input  logic [1:0]    slv1_mode,
   input  logic [DW-1:0] slv1_data,
   input  logic          slv1_data_valid,
   input  logic [7:0]    slv1_proc_val,
   output logic          slv1_ready,
   input  logic          fifo_full,
   input  logic          mstr_cmplt,
   output logic          fifo_wr_en,
   output logic [DW-1:0] fifo_wr_data,
   output logic [1:0]    slvx_mode,
   output logic [7:0]    slvx_proc_val,
   output logic          data_source,
   output logic          burst_done,
   output logic          burst_abort
);

   sched_state_t  state_q, state_d;
   logic          grant_q, grant_d;
   logic          rr_q, rr_d;
   mode_t         mode_q, mode_d;
   logic [7:0]    pv_q, pv_d;
   logic          wr_en_q, wr_en_d;
   logic [DW-1:0] wr_data_q, wr_data_d;
   logic          done_q, done_d;
   logic          abort_q, abort_d;

   logic          req0, req1;
   mode_t         granted_mode;
   logic          abort_now;
   logic          grant_ok;
   logic          beat;
   logic          cnt_last;

   assign req0         = (slv0_mode != MODE_NONE);
   assign req1         = (slv1_mode != MODE_NONE);
   assign granted_mode = grant_q ? slv1_mode : slv0_mode;
   // A dropped mode closes the burst that cycle, so ready is withheld to avoid taking a beat.
   assign abort_now    = (state_q == GRANT) && (granted_mode == MODE_NONE);
   assign grant_ok     = (state_q == GRANT) && !fifo_full && !abort_now;
   assign slv0_ready   = grant_ok && !grant_q;
   assign slv1_ready   = grant_ok && grant_q;
   assign beat         = (slv0_ready && slv0_data_valid) || (slv1_ready && slv1_data_valid);

   burst_counter #(.BURST_LEN(BURST_LEN)) u_counter (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q == IDLE),
      .inc   (beat),
      .last  (cnt_last)
   );

`ifndef SCHED_WAIT_CMPLT_EN
   logic unused_cmplt;
   assign unused_cmplt = mstr_cmplt;
`endif

   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      rr_d      = rr_q;
      mode_d    = mode_q;
      pv_d      = pv_q;
      wr_en_d   = beat;
      wr_data_d = beat ? (grant_q ? slv1_data : slv0_data) : wr_data_q;
      done_d    = 1'b0;
      abort_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (req0 || req1) begin
               grant_d = pick_slave(req0, req1, rr_q);
               mode_d  = grant_d ? slv1_mode : slv0_mode;
               pv_d    = grant_d ? slv1_proc_val : slv0_proc_val;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (abort_now) begin
               done_d  = 1'b1;
               abort_d = 1'b1;
               rr_d    = !grant_q;
               state_d = DRAIN;
            end else if (beat && cnt_last) begin
               done_d  = 1'b1;
               rr_d    = !grant_q;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
`ifdef SCHED_WAIT_CMPLT_EN
            if (mstr_cmplt) begin
               state_d = IDLE;
            end
`else
            state_d = IDLE;
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         grant_q   <= 1'b0;
         rr_q      <= 1'b0;
         mode_q    <= MODE_NONE;
         pv_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_data_q <= '0;
         done_q    <= 1'b0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         rr_q      <= rr_d;
         mode_q    <= mode_d;
         pv_q      <= pv_d;
         wr_en_q   <= wr_en_d;
         wr_data_q <= wr_data_d;
         done_q    <= done_d;
         abort_q   <= abort_d;
      end
   end

   assign fifo_wr_en    = wr_en_q;
   assign fifo_wr_data  = wr_data_q;
   assign slvx_mode     = mode_q;
   assign slvx_proc_val = pv_q;
   assign data_source   = grant_q;
   assign burst_done    = done_q;
   assign burst_abort   = abort_q;

endmodule

// File: tb/tb_burst_rr_scheduler.sv
// Randomized self-checking bench for burst_rr_scheduler against a burst-level reference model.
// Follows SCHED_WAIT_CMPLT_EN the same way as the design when it is defined.
module tb_burst_rr_scheduler;

   localparam int DW = 32;
   localparam int BL = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [1:0]    slv0_mode, slv1_mode;
   logic [DW-1:0] slv0_data, slv1_data;
   logic          slv0_data_valid, slv1_data_valid;
   logic [7:0]    slv0_proc_val, slv1_proc_val;
   logic          slv0_ready, slv1_ready;
   logic          fifo_full;
   logic          mstr_cmplt;
   logic          fifo_wr_en;
   logic [DW-1:0] fifo_wr_data;
   logic [1:0]    slvx_mode;
   logic [7:0]    slvx_proc_val;
   logic          data_source;
   logic          burst_done;
   logic          burst_abort;

   always #5 clk = ~clk;

   burst_rr_scheduler #(.DW(DW), .BURST_LEN(BL)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .slv0_mode       (slv0_mode),
      .slv0_data       (slv0_data),
      .slv0_data_valid (slv0_data_valid),
      .slv0_proc_val   (slv0_proc_val),
      .slv0_ready      (slv0_ready),
      .slv1_mode       (slv1_mode),
      .slv1_data       (slv1_data),
      .slv1_data_valid (slv1_data_valid),
      .slv1_proc_val   (slv1_proc_val),
      .slv1_ready      (slv1_ready),
      .fifo_full       (fifo_full),
      .mstr_cmplt      (mstr_cmplt),
      .fifo_wr_en      (fifo_wr_en),
      .fifo_wr_data    (fifo_wr_data),
      .slvx_mode       (slvx_mode),
      .slvx_proc_val   (slvx_proc_val),
      .data_source     (data_source),
      .burst_done      (burst_done),
      .burst_abort     (burst_abort)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: who owns the bus, how many beats it has delivered, and whether a gap is pending.
   bit          m_busy, m_gap, m_owner, m_pref;
   int          m_taken;
   int          m_bursts;
   logic        e_rdy0, e_rdy1;
   logic        e_wr_en;
   logic [31:0] e_wr_data;
   logic        e_src;
   logic [1:0]  e_mode;
   logic [7:0]  e_pv;
   logic        e_done, e_abort;

   int p_req0, p_req1, p_valid, p_full, p_drop;
   bit hold0, hold1, force_pv;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_busy = 0; m_gap = 0; m_owner = 0; m_pref = 0; m_taken = 0;
      e_wr_en = 0; e_wr_data = '0; e_src = 0; e_mode = '0; e_pv = '0;
      e_done = 0; e_abort = 0;
   endtask

   task automatic applyStimulus();
      if (!hold0) hold0 = ($urandom_range(99) < p_req0);
      else if ($urandom_range(99) < p_drop) hold0 = 0;
      if (!hold1) hold1 = ($urandom_range(99) < p_req1);
      else if ($urandom_range(99) < p_drop) hold1 = 0;
      slv0_mode       = hold0 ? (force_pv ? 2'b01 : 2'($urandom_range(1, 3))) : 2'b00;
      slv1_mode       = hold1 ? 2'($urandom_range(1, 3)) : 2'b00;
      slv0_proc_val   = force_pv ? 8'h3C : 8'($urandom);
      slv1_proc_val   = 8'($urandom);
      slv0_data       = $urandom;
      slv1_data       = $urandom;
      slv0_data_valid = ($urandom_range(99) < p_valid);
      slv1_data_valid = ($urandom_range(99) < p_valid);
      fifo_full       = ($urandom_range(99) < p_full);
      mstr_cmplt      = ($urandom_range(99) < 15);
   endtask

   // Evaluate one cycle of the specification against the inputs currently applied.
   task automatic modelStep();
      logic [1:0] omode;
      omode   = m_owner ? slv1_mode : slv0_mode;
      e_rdy0  = m_busy && !m_owner && !fifo_full && (omode != 2'b00);
      e_rdy1  = m_busy &&  m_owner && !fifo_full && (omode != 2'b00);
      e_wr_en = 0; e_done = 0; e_abort = 0;
      if (m_busy) begin
         if (omode == 2'b00) begin
            m_busy = 0; m_gap = 1; e_done = 1; e_abort = 1; m_pref = !m_owner; m_bursts++;
         end else if ((e_rdy0 && slv0_data_valid) || (e_rdy1 && slv1_data_valid)) begin
            e_wr_en   = 1;
            e_wr_data = m_owner ? slv1_data : slv0_data;
            m_taken++;
            if (m_taken == BL) begin
               m_busy = 0; m_gap = 1; e_done = 1; m_pref = !m_owner; m_bursts++;
            end
         end
      end else if (m_gap) begin
`ifdef SCHED_WAIT_CMPLT_EN
         if (mstr_cmplt) m_gap = 0;
`else
         m_gap = 0;
`endif
      end else if (slv0_mode != 2'b00 || slv1_mode != 2'b00) begin
         if (slv0_mode != 2'b00 && slv1_mode != 2'b00) m_owner = m_pref;
         else m_owner = (slv0_mode == 2'b00);
         m_busy  = 1;
         m_taken = 0;
         e_src   = m_owner;
         e_mode  = m_owner ? slv1_mode : slv0_mode;
         e_pv    = m_owner ? slv1_proc_val : slv0_proc_val;
      end
   endtask

   task automatic checkRegs();
      checkOutput("fifo_wr_en", fifo_wr_en, e_wr_en);
      if (e_wr_en) checkOutput("fifo_wr_data", fifo_wr_data, e_wr_data);
      checkOutput("data_source", data_source, e_src);
      checkOutput("slvx_mode", slvx_mode, e_mode);
      checkOutput("slvx_proc_val", slvx_proc_val, e_pv);
      checkOutput("burst_done", burst_done, e_done);
      checkOutput("burst_abort", burst_abort, e_abort);
   endtask

   task automatic checkResetOutputs(input string tag);
      checkOutput({tag, "_ready0"}, slv0_ready, 1'b0);
      checkOutput({tag, "_ready1"}, slv1_ready, 1'b0);
      checkOutput({tag, "_wr_en"}, fifo_wr_en, 1'b0);
      checkOutput({tag, "_wr_data"}, fifo_wr_data, 32'h0);
      checkOutput({tag, "_mode"}, slvx_mode, 2'b00);
      checkOutput({tag, "_pv"}, slvx_proc_val, 8'h00);
      checkOutput({tag, "_src"}, data_source, 1'b0);
      checkOutput({tag, "_done"}, burst_done, 1'b0);
      checkOutput({tag, "_abort"}, burst_abort, 1'b0);
   endtask

   task automatic oneCycle();
      applyStimulus();
      #1;
      modelStep();
      checkOutput("slv0_ready", slv0_ready, e_rdy0);
      checkOutput("slv1_ready", slv1_ready, e_rdy1);
      @(posedge clk);
      #1;
      checkRegs();
   endtask

   task automatic runCycles(input int n);
      repeat (n) oneCycle();
   endtask

   initial begin
      hold0 = 0; hold1 = 0; force_pv = 0; m_bursts = 0;
      p_req0 = 0; p_req1 = 0; p_valid = 0; p_full = 0; p_drop = 0;
      rst_n = 1'b0;
      applyStimulus();
      modelReset();
      #12;
      checkResetOutputs("reset");
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] slv0 alone, valid held");
      force_pv = 1; p_req0 = 100; p_valid = 100;
      runCycles(40);
      force_pv = 0;

      $display("[TB] both slaves requesting continuously");
      p_req1 = 100;
      runCycles(80);

      $display("[TB] random fifo_full and valid gaps");
      p_valid = 70; p_full = 25;
      runCycles(150);

      $display("[TB] mode drops causing aborts");
      p_drop = 6; p_req0 = 40; p_req1 = 40;
      runCycles(300);

      $display("[TB] fully random mix");
      p_req0 = 30; p_req1 = 60; p_valid = 60; p_full = 15; p_drop = 3;
      runCycles(400);

      $display("[TB] reset during a burst");
      p_req0 = 100; p_req1 = 100; p_valid = 100; p_full = 0; p_drop = 0;
      for (int k = 0; k < 200 && !(m_busy && m_taken == 6); k++) oneCycle();
      checkOutput("reached_beat7", (m_busy && m_taken == 6), 1'b1);
      rst_n = 1'b0;
      #1;
      checkResetOutputs("midreset");
      modelReset();
      #1;
      rst_n = 1'b1;
      runCycles(60);

      checkOutput("bursts_seen", (m_bursts > 20), 1'b1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/burst_rr_scheduler.md
# burst_rr_scheduler

Two-requester, burst-granular round-robin scheduler between the two image-source slaves (slv0, slv1) and the shared input FIFO of the processing datapath. It grants one slave for a burst of up to BURST_LEN beats and latches that slave's mode and proc_val as burst sideband. It forwards accepted beats to the FIFO with one-cycle latency and alternates priority at burst boundaries. Optionally it holds off the next grant until the downstream master reports completion.

## Interface
- DW, 32, pixel data width
- BURST_LEN, 16, max beats per grant (≥2)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- slv0_mode / slv1_mode  in  2  requested processing mode; 2'b00 = no request
- slv0_data / slv1_data  in  DW  pixel beat
- slv0_data_valid / slv1_data_valid  in  1  beat valid
- slv0_proc_val / slv1_proc_val  in  8  processing parameter
- slv0_ready / slv1_ready  out  1  beat accept (combinational)
- fifo_full  in  1  FIFO almost-full; asserted with ≥1 free entry remaining
- mstr_cmplt  in  1  single-cycle pulse, downstream burst processed
- fifo_wr_en  out  1  FIFO write strobe
- fifo_wr_data  out  DW  FIFO write data
- slvx_mode  out  2  latched mode of the current/last burst
- slvx_proc_val  out  8  latched proc_val
- data_source  out  1  granted slave index
- burst_done  out  1  single-cycle pulse at burst end
- burst_abort  out  1  single-cycle pulse when a burst ends through mode drop

## Operation
- States: IDLE, GRANT, DRAIN.
- IDLE: a request is slvN_mode != 0. If both slaves request, the rr pointer picks; if one requests, it wins. Next state is GRANT. On entry, the block latches data_source, slvx_mode and slvx_proc_val and clears the beat counter.
- rr pointer resets to slv0. After any burst from N ends, the pointer moves to the other slave.
- GRANT: slvN_ready = (grant==N) && !fifo_full. The non-granted ready is 0.
- A beat is slvN_ready && slvN_data_valid. Each beat increments the counter; counter width is $clog2(BURST_LEN+1).
- Normal end: a beat while count==BURST_LEN-1. burst_done pulses and the state moves to DRAIN.
- Abort: the granted slave's mode reads 00 while in GRANT. No beat is taken that cycle. burst_done and burst_abort pulse, and the state moves to DRAIN.
- A nonzero mode change mid-burst is ignored; the latched value holds.
- DRAIN: move to IDLE (see Configuration). mstr_cmplt outside DRAIN is ignored.
- fifo_wr_en/fifo_wr_data are registered copies of the beat: write occurs the cycle after acceptance. fifo_full is sampled combinationally into ready.

## Timing
- Reset values: all outputs 0 and fifo_wr_data = 0. State is IDLE, pointer is slv0, counter is 0.
- Grant latency: a request seen in IDLE at cycle t gives GRANT at t+1, with ready possible at t+1.
- Beat-to-FIFO latency: 1 cycle. With valid held and no full, the block sustains 1 beat/cycle.
- Between bursts there is at least 1 DRAIN cycle and 1 IDLE cycle, so the next ready comes ≥2 cycles after the last beat.
- fifo_full rising the same cycle as a beat: the beat is blocked, because ready is already 0. The in-flight registered write always fits because of the almost-full slack.
- Reset mid-burst: asynchronous clear. A pending registered write is dropped and the pointer returns to slv0.

## Configuration
- SCHED_WAIT_CMPLT_EN defined: DRAIN holds until mstr_cmplt=1, then goes to IDLE. A mstr_cmplt in the same cycle as DRAIN entry does not count; only pulses seen while in DRAIN count.
- SCHED_WAIT_CMPLT_EN not defined: DRAIN lasts exactly 1 cycle, and mstr_cmplt is unused.

## Structure
- Package sched_pkg holds:
  - state enum sched_state_t {IDLE, GRANT, DRAIN};
  - typedef mode_t (logic [1:0]);
  - constant MODE_NONE = 2'b00.
- One sub-module, burst_counter: beat counter with clear, increment and last flag, parameterised by BURST_LEN.

## Test plan
- Only slv0 requests (mode=01, proc_val=8'h3C), valid held, BURST_LEN=16 -> 16 writes on consecutive cycles starting 1 cycle after first ready; data_source=0; slvx_proc_val=8'h3C; one burst_done.
- Both request continuously -> grants alternate slv0, slv1, slv0; exactly 16 beats each; ≥2-cycle gap between bursts.
- fifo_full asserted for 3 cycles mid-burst after beat 5 -> ready low for those 3 cycles; no write lost or duplicated; burst completes at 16 beats.
- slv1 drops mode to 00 after 4 beats -> exactly 4 writes; burst_abort and burst_done pulse together; next grant goes to slv0.
- With SCHED_WAIT_CMPLT_EN defined, mstr_cmplt delayed 10 cycles after burst end -> no ready during those cycles; grant 1 cycle after the pulse. Without the macro -> IDLE 1 cycle after burst end.
- rst_n low during beat 7 -> all outputs 0 immediately; after release, first grant goes to slv0.
